// File: rtl/boot_loader.sv
// Purpose: after reset (or a boot_req in DONE) write a fixed 5-word bootstrap image into RAM, then release the CPU at START_PC.
// Latency: SETTLE+1 cycles to the first write, at least 2 cycles per word, then one load_pc cycle before cpu_hold drops.
// Backpressure: a write is held with stable address/data until ram_ack; at most one write is outstanding, and there is no timeout.
//
// Ports:
//   clk, reset      single clock; asynchronous active-low reset
//   boot_req        one-cycle reload request, honoured only in DONE
//   ram_addr/_data  write address/data, valid while ram_wr=1
//   ram_wr/ram_ack  write request held until ram_ack is seen with ram_wr=1
//   cpu_hold        CPU halted while 1
//   load_pc         one-cycle pulse telling the CPU to load start_pc
//   start_pc        constant START_PC
//   busy            1 in every state except DONE
module boot_loader #(
    parameter logic [14:0] BASE_ADDR = 15'o07750,
    parameter logic [11:0] START_PC  = 12'o07750,
    parameter int unsigned SETTLE    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_req,
    output logic [14:0] ram_addr,
    output logic [11:0] ram_data,
    output logic        ram_wr,
    input  logic        ram_ack,
    output logic        cpu_hold,
    output logic        load_pc,
    output logic [11:0] start_pc,
    output logic        busy
);

    localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);
    localparam logic [2:0] LAST_IDX   = 3'd4;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_WRITE,
        ST_NEXT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [14:0] ram_addr_q;
    logic [11:0] ram_data_q;
    logic        ram_wr_q;
    logic        load_pc_q;
    logic        cpu_hold_q;
    logic        busy_q;

    // Bootstrap image, one 12-bit word per index.
    function automatic logic [11:0] image_word(input logic [2:0] i);
        logic [11:0] w;
        case (i)
            3'd0:    w = 12'o7600;
            3'd1:    w = 12'o6603;
            3'd2:    w = 12'o6622;
            3'd3:    w = 12'o5352;
            3'd4:    w = 12'o5752;
            default: w = 12'o0000;
        endcase
        return w;
    endfunction

    assign idx_d = idx_q + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= SETTLE_CNT;
            idx_q      <= 3'd0;
            ram_wr_q   <= 1'b0;
            load_pc_q  <= 1'b0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
            ram_addr_q <= BASE_ADDR;
            ram_data_q <= 12'o7600;
        end else begin
            // load_pc is only ever a single-cycle pulse.
            load_pc_q <= 1'b0;
            case (state_q)
                ST_SETTLE: begin
                    // Counter reads 0 on the cycle we leave, so SETTLE=0 spends one cycle here.
                    if (cnt_q == 3'd0) begin
                        state_q    <= ST_WRITE;
                        ram_wr_q   <= 1'b1;
                        ram_addr_q <= BASE_ADDR + {12'd0, idx_q};
                        ram_data_q <= image_word(idx_q);
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_WRITE: begin
                    // Address/data are untouched until the write is accepted.
                    if (ram_ack) begin
                        state_q  <= ST_NEXT;
                        ram_wr_q <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    idx_q <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        state_q   <= ST_RELEASE;
                        load_pc_q <= 1'b1;
                    end else begin
                        // 15-bit add wraps naturally past 77777.
                        state_q    <= ST_WRITE;
                        ram_wr_q   <= 1'b1;
                        ram_addr_q <= BASE_ADDR + {12'd0, idx_d};
                        ram_data_q <= image_word(idx_d);
                    end
                end
                ST_RELEASE: begin
                    state_q    <= ST_DONE;
                    cpu_hold_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                ST_DONE: begin
                    // Requests outside DONE are dropped, never remembered.
                    if (boot_req) begin
                        state_q    <= ST_SETTLE;
                        cnt_q      <= SETTLE_CNT;
                        idx_q      <= 3'd0;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                        ram_addr_q <= BASE_ADDR;
                        ram_data_q <= 12'o7600;
                    end
                end
                default: begin
                    state_q    <= ST_SETTLE;
                    cnt_q      <= SETTLE_CNT;
                    idx_q      <= 3'd0;
                    ram_wr_q   <= 1'b0;
                    cpu_hold_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_wr   = ram_wr_q;
    assign load_pc  = load_pc_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign start_pc = START_PC;

endmodule
